operand_select_stage: RTL and testbench
=======================================

# operand_select_stage

Parametrised ALU operand selector with a registered, back-pressured output stage. It picks one of `NUM_SRC` candidate operands, or a forwarded value that overrides the select. The chosen word, plus an illegal-select flag, is captured into a two-entry skid register and presented to the execute stage under a valid/ready handshake. It sits between decode and the ALU, replacing the fixed 2-way srcB select. Flush support and a saturating illegal-select counter are added for debug.

## Interface
- `WIDTH`, default 32: operand width in bits.
- `NUM_SRC`, default 4: number of candidate sources, 2..16.
- `SEL_W`, default `$clog2(NUM_SRC)` (min 1): select width.
- `BAD_VALUE`, default `32'h0BADBAD0` (truncated/zero-extended to `WIDTH`): poison word for an illegal select.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: stage can accept; registered.
- `sel` in `SEL_W`: source index.
- `src_data` in `NUM_SRC*WIDTH`: flattened sources; source k = bits [k*WIDTH +: WIDTH].
- `fwd_en` in 1: forwarding override.
- `fwd_data` in `WIDTH`: forwarded operand.
- `flush` in 1: discard all held entries.
- `out_valid` out 1: `out_data` valid.
- `out_ready` in 1: consumer accepts.
- `out_data` out `WIDTH`: selected operand.
- `out_bad_sel` out 1: the entry came from an illegal select.
- `bad_sel_count` out 8: saturating count of accepted illegal selects.

## Operation
- Accept: `in_valid && in_ready && !flush`.
- Select priority:
  - If `fwd_en`, select `fwd_data`; `bad` = 0.
  - Else if `sel < NUM_SRC`, select source `sel`; `bad` = 0.
  - Else select `BAD_VALUE`; `bad` = 1.
- Buffer states:
  - EMPTY: `out_valid`=0, `in_ready`=1.
  - ONE: output reg valid, `in_ready`=1.
  - TWO: output and skid regs valid, `in_ready`=0.
- Transitions (no flush; "pop" = `out_valid && out_ready`):
  - EMPTY + accept → ONE.
  - ONE + accept, no pop → TWO; the new entry goes to the skid reg.
  - ONE + accept + pop → ONE; the new entry goes to the output reg.
  - ONE + pop, no accept → EMPTY.
  - TWO + pop → ONE; skid moves to the output reg.
  - TWO, no pop → TWO.
- Entries leave in strict acceptance order. No entry is dropped or duplicated except by flush.
- `flush`: next state EMPTY regardless of accept or pop. Any input presented that cycle is discarded and not counted. A pop in the same cycle still completes for the consumer.
- `bad_sel_count`: +1 on each accept with `bad`=1. Saturates at 255. Cleared only by reset, never by flush.
- `out_data` and `out_bad_sel` hold their last value when `out_valid`=0. They change only on a load.

## Timing
- Reset values (asserted asynchronously): state EMPTY, `in_ready`=1, `out_valid`=0, `out_data`=0, `out_bad_sel`=0, `bad_sel_count`=0, skid reg 0.
- Latency: accept in cycle N gives `out_valid`=1 in cycle N+1 (from EMPTY, or ONE with a pop).
- Throughput: one transfer per cycle while `out_ready`=1.
- `in_ready` is a flop output with no combinational path from `out_ready`. `out_valid` and `out_data` are flop outputs.
- `out_valid` stays 1 and `out_data` stays stable until a pop or flush.
- Reset mid-transfer: all held entries are lost and outputs go to reset values immediately. The first accept is allowed on the first rising edge after `RST_N` deasserts.

## Structure
- Package `operand_pkg` holds:
  - the `buf_state_t` enum {EMPTY, ONE, TWO};
  - the `BAD_VALUE_DEFAULT` constant (`32'h0BADBAD0`);
  - the `CNT_W` = 8 constant.
- Sub-module `operand_skid_reg`: generic `WIDTH+1`-bit two-entry skid buffer with valid/ready and flush. The top level adds the select logic and the counter.

## Test plan
- Reset release, `NUM_SRC`=4, src k = 0x1000+k, `sel`=2, `in_valid`=1 one cycle, `out_ready`=1 → next cycle `out_valid`=1, `out_data`=0x1002, `out_bad_sel`=0.
- `fwd_en`=1, `fwd_data`=0xDEADBEEF, `sel`=3 → `out_data`=0xDEADBEEF.
- `NUM_SRC`=3, `sel`=3 accepted → `out_data`=0x0BADBAD0, `out_bad_sel`=1, `bad_sel_count`=1; after 300 such accepts the count reads 255.
- `out_ready`=0, stream values 1,2,3 → `in_ready` falls after 2 accepts and value 3 is held. Raising `out_ready` then yields 1,2,3 in order with no gaps or duplicates.
- In state TWO, assert `flush` with `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1, count unchanged.
- Assert `RST_N`=0 mid-stream, asynchronously between edges → `out_valid`=0 immediately and the count is cleared.

Source files
------------

// File: rtl/operand_select_stage_pkg.sv
// Shared types and constants for the operand select stage.
package operand_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } buf_state_t;

  localparam logic [31:0] BAD_VALUE_DEFAULT = 32'h0BAD_BAD0;
  localparam int unsigned CNT_W             = 8;

endpackage

// File: rtl/operand_select_stage_if.sv
// Decode-side request and execute-side response signals of the operand select stage.
interface operand_select_stage_if
  import operand_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned SEL_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
);

  logic                     in_valid;
  logic                     in_ready;
  logic [SEL_W-1:0]         sel;
  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic                     fwd_en;
  logic [WIDTH-1:0]         fwd_data;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic                     out_bad_sel;
  logic [CNT_W-1:0]         bad_sel_count;

  modport master (
    output in_valid, sel, src_data, fwd_en, fwd_data, flush, out_ready,
    input  in_ready, out_valid, out_data, out_bad_sel, bad_sel_count
  );

  modport slave (
    input  in_valid, sel, src_data, fwd_en, fwd_data, flush, out_ready,
    output in_ready, out_valid, out_data, out_bad_sel, bad_sel_count
  );

endinterface

// File: rtl/operand_select_stage_skid.sv
// Two-entry skid buffer: registered in_ready/out_valid/out_data, flush empties it.
module operand_skid_reg
  import operand_pkg::*;
#(
  parameter int unsigned W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  buf_state_t   state;
  logic [W-1:0] skid_q;
  logic         accept;
  logic         pop;

  assign accept = in_valid && in_ready && !flush;
  assign pop    = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_q    <= '0;
    end else if (flush) begin
      // Data registers keep their contents so out_data holds while invalid.
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            out_data <= in_data;
          end else if (accept) begin
            skid_q   <= in_data;
            in_ready <= 1'b0;
            state    <= TWO;
          end else if (pop) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            out_data <= skid_q;
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/operand_select_stage.sv
// ALU operand selector: forward/source/poison select feeding a registered skid output.
module operand_select_stage
  import operand_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned SEL_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  parameter logic [31:0] BAD_VALUE = BAD_VALUE_DEFAULT
) (
  input logic                   CLK,
  input logic                   RST_N,
  operand_select_stage_if.slave bus
);

  localparam logic [WIDTH-1:0] BAD_WORD = WIDTH'(BAD_VALUE);

  logic [WIDTH-1:0] sel_data;
  logic             sel_bad;
  logic             accept;
  logic [WIDTH:0]   out_word;
  logic [CNT_W-1:0] bad_cnt;

  always_comb begin
    sel_data = BAD_WORD;
    sel_bad  = 1'b1;
    if (bus.fwd_en) begin
      sel_data = bus.fwd_data;
      sel_bad  = 1'b0;
    end else begin
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
        if (bus.sel == SEL_W'(k)) begin
          sel_data = bus.src_data[k*WIDTH +: WIDTH];
          sel_bad  = 1'b0;
        end
      end
    end
  end

  assign accept = bus.in_valid && bus.in_ready && !bus.flush;

  operand_skid_reg #(
    .W(WIDTH + 1)
  ) u_skid (
    .clk      (CLK),
    .rst_n    (RST_N),
    .in_valid (bus.in_valid),
    .in_ready (bus.in_ready),
    .in_data  ({sel_bad, sel_data}),
    .flush    (bus.flush),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready),
    .out_data (out_word)
  );

  assign bus.out_bad_sel = out_word[WIDTH];
  assign bus.out_data    = out_word[WIDTH-1:0];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bad_cnt <= '0;
    end else if (accept && sel_bad && (bad_cnt != '1)) begin
      bad_cnt <= bad_cnt + 1'b1;
    end
  end

  assign bus.bad_sel_count = bad_cnt;

endmodule

// File: tb/tb_operand_select_stage.sv
// Scoreboard bench for operand_select_stage with NUM_SRC=3 (sel=3 is an illegal select).
module tb_operand_select_stage;

  logic CLK;
  logic RST_N;

  int compared   = 0;
  int mismatched = 0;

  typedef logic [32:0] exp_t;
  exp_t exp_q[$];

  operand_select_stage_if #(.WIDTH(32), .NUM_SRC(3), .SEL_W(2)) bus ();

  operand_select_stage #(
    .WIDTH  (32),
    .NUM_SRC(3),
    .SEL_W  (2)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every pop is compared against the oldest expected entry.
  always @(negedge CLK) begin
    if (RST_N && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_pop: got %0h expected none", bus.out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pop_data", 64'(bus.out_data), 64'(e[31:0]));
        check("pop_bad", 64'(bus.out_bad_sel), 64'(e[32]));
      end
    end
  end

  task automatic send(input logic [1:0] s, input logic f, input logic [31:0] fd,
                      input logic eb, input logic [31:0] ed);
    int unsigned n = 0;
    bus.sel      = s;
    bus.fwd_en   = f;
    bus.fwd_data = fd;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    if (!bus.in_ready) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end else begin
      exp_q.push_back({eb, ed});
      @(posedge CLK); #1;
    end
    bus.in_valid = 1'b0;
    bus.fwd_en   = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N        = 1'b0;
    bus.in_valid = 1'b0;
    bus.sel      = '0;
    bus.src_data = {32'h0000_1002, 32'h0000_1001, 32'h0000_1000};
    bus.fwd_en   = 1'b0;
    bus.fwd_data = '0;
    bus.flush    = 1'b0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge CLK);
    #3;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_bad", 64'(bus.out_bad_sel), 64'd0);
    check("rst_count", 64'(bus.bad_sel_count), 64'd0);
    @(negedge CLK); #2;
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Plain source select, one-cycle latency
    send(2'd2, 1'b0, 32'h0, 1'b0, 32'h0000_1002);
    check("lat_out_valid", 64'(bus.out_valid), 64'd1);
    check("lat_out_data", 64'(bus.out_data), 64'h1002);

    // Forward overrides an otherwise illegal select
    send(2'd3, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF);
    check("fwd_count", 64'(bus.bad_sel_count), 64'd0);

    send(2'd3, 1'b0, 32'h0, 1'b1, 32'h0BAD_BAD0);
    check("bad_count1", 64'(bus.bad_sel_count), 64'd1);
    check("bad_out_sel", 64'(bus.out_bad_sel), 64'd1);
    send(2'd0, 1'b0, 32'h0, 1'b0, 32'h0000_1000);
    drain();

    // Back-pressure: two entries fill the buffer, third waits
    bus.out_ready = 1'b0;
    send(2'd0, 1'b1, 32'd1, 1'b0, 32'd1);
    send(2'd0, 1'b1, 32'd2, 1'b0, 32'd2);
    fork
      begin
        repeat (3) begin
          check("bp_in_ready", 64'(bus.in_ready), 64'd0);
          check("bp_hold_data", 64'(bus.out_data), 64'd1);
          @(posedge CLK); #1;
        end
        bus.out_ready = 1'b1;
      end
      send(2'd0, 1'b1, 32'd3, 1'b0, 32'd3);
    join
    drain();

    // Flush in TWO with an illegal select presented: discarded and not counted
    bus.out_ready = 1'b0;
    send(2'd1, 1'b0, 32'h0, 1'b0, 32'h0000_1001);
    send(2'd2, 1'b0, 32'h0, 1'b0, 32'h0000_1002);
    check("two_in_ready", 64'(bus.in_ready), 64'd0);
    bus.sel      = 2'd3;
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    exp_q.delete();
    @(posedge CLK); #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_in_ready", 64'(bus.in_ready), 64'd1);
    check("flush_count", 64'(bus.bad_sel_count), 64'd1);
    check("flush_hold_data", 64'(bus.out_data), 64'h1001);
    bus.out_ready = 1'b1;

    // Counter saturation
    for (int i = 0; i < 254; i++) send(2'd3, 1'b0, 32'h0, 1'b1, 32'h0BAD_BAD0);
    check("sat_count255", 64'(bus.bad_sel_count), 64'd255);
    for (int i = 0; i < 45; i++) send(2'd3, 1'b0, 32'h0, 1'b1, 32'h0BAD_BAD0);
    check("sat_count_hold", 64'(bus.bad_sel_count), 64'd255);
    drain();

    // Asynchronous reset mid-stream
    bus.out_ready = 1'b0;
    send(2'd0, 1'b1, 32'h55, 1'b0, 32'h55);
    send(2'd0, 1'b1, 32'h66, 1'b0, 32'h66);
    #2;
    RST_N = 1'b0;
    exp_q.delete();
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_in_ready", 64'(bus.in_ready), 64'd1);
    check("arst_count", 64'(bus.bad_sel_count), 64'd0);
    check("arst_out_data", 64'(bus.out_data), 64'd0);
    @(negedge CLK); #2;
    RST_N        = 1'b1;
    bus.sel      = 2'd1;
    bus.in_valid = 1'b1;
    exp_q.push_back({1'b0, 32'h0000_1001});
    @(posedge CLK); #1;
    bus.in_valid = 1'b0;
    check("post_rst_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
